step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 89 ++++++++
 tb/tb_step_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: per-instruction control-step counter with a retired-instruction count.
// Step runs 1..effective limit, then restarts at 1 and bumps InstrCount.
// Step is 0 only after reset.
// Optional build macro STEP_SEQ_ONEHOT_EN enables the StepOneHot decoder.
// Without it, StepOneHot is tied to zero.
module step_sequencer #(
    parameter int MAX_STEPS = 5,
    parameter int STEP_W    = 3,
    parameter int INSTR_W   = 16
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Stall,
    input  logic                 EndInstr,
    input  logic [STEP_W-1:0]    StepLimit,
    output logic [STEP_W-1:0]    Step,
    output logic [MAX_STEPS-1:0] StepOneHot,
    output logic                 FirstStep,
    output logic                 LastStep,
    output logic [INSTR_W-1:0]   InstrCount
);

    localparam logic [STEP_W-1:0]  MAX_S   = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0]  STEP_1  = STEP_W'(1);
    localparam logic [INSTR_W-1:0] INSTR_1 = INSTR_W'(1);

    logic [STEP_W-1:0]    r_step;
    logic [INSTR_W-1:0]   r_instr_cnt;
    logic [STEP_W-1:0]    w_limit;
    logic                 w_at_end;
    logic [MAX_STEPS-1:0] w_onehot;

    // Effective limit: out-of-range StepLimit (0 or above MAX_STEPS) selects MAX_STEPS.
    always_comb begin
        w_limit = StepLimit;
        if ((StepLimit == '0) || (StepLimit > MAX_S)) begin
            w_limit = MAX_S;
        end
    end

    // Current step has reached the limit; a limit lowered below Step also counts.
    always_comb begin
        w_at_end = (r_step != '0) && (r_step >= w_limit);
    end

    // Step / instruction counter update: Stall, then idle, then end-of-instruction, then advance.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_step      <= '0;
            r_instr_cnt <= '0;
        end else if (Stall) begin
            r_step      <= r_step;
            r_instr_cnt <= r_instr_cnt;
        end else if (r_step == '0) begin
            r_step      <= STEP_1;
        end else if (EndInstr || w_at_end) begin
            r_step      <= STEP_1;
            r_instr_cnt <= r_instr_cnt + INSTR_1;
        end else begin
            r_step      <= r_step + STEP_1;
        end
    end

`ifdef STEP_SEQ_ONEHOT_EN
    // One-hot decode of Step: bit k-1 set when Step == k; all-zero while idle.
    always_comb begin
        w_onehot = '0;
        for (int unsigned k = 0; k < MAX_STEPS; k++) begin
            w_onehot[k] = (r_step == STEP_W'(k + 1));
        end
    end
`else
    // Decoder not built: port kept, tied low.
    always_comb begin
        w_onehot = '0;
    end
`endif

    // Zero-latency status flags; EndInstr deliberately has no influence on LastStep.
    always_comb begin
        FirstStep = (r_step == STEP_1);
        LastStep  = w_at_end;
    end

    assign Step       = r_step;
    assign InstrCount = r_instr_cnt;
    assign StepOneHot = w_onehot;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench for step_sequencer.
// Stimulus pushes expected results into a queue.
// A monitor pops and compares them after each clock edge or reset assertion.
module tb_step_sequencer;

    localparam int MAX   = 5;
    localparam int SW    = 3;
    localparam int IW    = 2;
    localparam int CMASK = (1 << IW) - 1;

    logic           Clock;
    logic           nReset;
    logic           Stall;
    logic           EndInstr;
    logic [SW-1:0]  StepLimit;
    logic [SW-1:0]  Step;
    logic [MAX-1:0] StepOneHot;
    logic           FirstStep;
    logic           LastStep;
    logic [IW-1:0]  InstrCount;

    typedef struct {
        int             step;
        int             cnt;
        bit             first;
        bit             last;
        logic [MAX-1:0] oh;
        string          tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: plain integers following the sequencing rules.
    int m_step = 0;
    int m_cnt  = 0;

    step_sequencer #(
        .MAX_STEPS(MAX),
        .STEP_W   (SW),
        .INSTR_W  (IW)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Stall     (Stall),
        .EndInstr  (EndInstr),
        .StepLimit (StepLimit),
        .Step      (Step),
        .StepOneHot(StepOneHot),
        .FirstStep (FirstStep),
        .LastStep  (LastStep),
        .InstrCount(InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int eff_limit(input int lim);
        return (lim == 0 || lim > MAX) ? MAX : lim;
    endfunction

    function automatic exp_t make_exp(input int lim, input string tag);
        exp_t e;
        e.step  = m_step;
        e.cnt   = m_cnt;
        e.first = (m_step == 1);
        e.last  = (m_step != 0) && (m_step >= eff_limit(lim));
        e.oh    = '0;
`ifdef STEP_SEQ_ONEHOT_EN
        if (m_step != 0) e.oh[m_step-1] = 1'b1;
`endif
        e.tag = tag;
        return e;
    endfunction

    // One clock cycle: drive inputs, advance the reference, queue the expectation.
    task automatic cyc(input bit st, input bit en, input int lim, input string tag);
        @(negedge Clock);
        Stall     = st;
        EndInstr  = en;
        StepLimit = SW'(lim);
        if (!st) begin
            if (m_step == 0) begin
                m_step = 1;
            end else if (en || m_step >= eff_limit(lim)) begin
                m_step = 1;
                m_cnt  = (m_cnt + 1) & CMASK;
            end else begin
                m_step = m_step + 1;
            end
        end
        sb.push_back(make_exp(lim, tag));
    endtask

    // Reset pulse between edges, then one unstalled edge after release.
    task automatic rst_pulse(input int lim, input string tag);
        @(negedge Clock);
        Stall     = 1'b0;
        EndInstr  = 1'b0;
        StepLimit = SW'(lim);
        m_step = 0;
        m_cnt  = 0;
        sb.push_back(make_exp(lim, {tag, "_rst"}));
        nReset = 1'b0;
        #4;
        nReset = 1'b1;
        m_step = 1;
        sb.push_back(make_exp(lim, {tag, "_rel"}));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: compare the oldest expectation after each edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock or negedge nReset);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".Step"},       32'(Step),       32'(e.step));
                chk({e.tag, ".InstrCount"}, 32'(InstrCount), 32'(e.cnt));
                chk({e.tag, ".FirstStep"},  32'(FirstStep),  32'(e.first));
                chk({e.tag, ".LastStep"},   32'(LastStep),   32'(e.last));
                chk({e.tag, ".StepOneHot"}, 32'(StepOneHot), 32'(e.oh));
            end
        end
    end

    initial begin
        int guard;
        int lim;
        Stall     = 1'b0;
        EndInstr  = 1'b0;
        StepLimit = '0;
        nReset    = 1'b1;

        rst_pulse(0, "init");
        // Free run: 11 more edges make 12 from release.
        for (int i = 0; i < 11; i++) cyc(0, 0, 0, "free");
        // Short instructions at limit 3, then out-of-range limit 7.
        for (int i = 0; i < 6; i++)  cyc(0, 0, 3, "lim3");
        for (int i = 0; i < 10; i++) cyc(0, 0, 7, "lim7");

        // Hold with Stall+EndInstr at Step 2, then EndInstr alone.
        guard = 0;
        while (m_step != 2 && guard < 10) begin
            cyc(0, 0, 0, "to2");
            guard++;
        end
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, "stall_end");
        cyc(0, 1, 0, "end_only");

        // Limit dropped from 5 to 2 while at Step 4.
        guard = 0;
        while (m_step != 4 && guard < 10) begin
            cyc(0, 0, 5, "to4");
            guard++;
        end
        cyc(0, 0, 2, "limdrop");

        // Counter wrap through several short instructions.
        for (int i = 0; i < 12; i++) cyc(0, 0, 2, "wrap");

        // Reset mid-instruction at Step 3.
        guard = 0;
        while (m_step != 3 && guard < 10) begin
            cyc(0, 0, 0, "to3");
            guard++;
        end
        rst_pulse(0, "mid");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            lim = int'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) rst_pulse(lim, "rnd");
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, lim, "rnd");
        end

        repeat (3) @(negedge Clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
